alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one 32-bit unsigned ALU instance between two independent requesters.
- Arbitrates requests, either round-robin or fixed-priority.
- Registers the granted command and drives the ALU for one execute cycle.
- Returns the registered result to the winning requester over a valid/ready response channel.
- Sits between requester logic and the ALU. The ALU stays purely combinational and is instantiated beside this block by its parent.

Parameters:
- RR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with requester 0 winning.
- GRANT_INIT, default 0: requester treated as most-recently-served after reset. Used only when RR=1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_opcode  input  3  ALU opcode from requester 0 (000 NOT … 111 ADD).
- req0_a  input  32  operand a from requester 0.
- req0_b  input  32  operand b from requester 0.
- req0_cin  input  1  carry-in from requester 0.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp0_valid  output  1  response pending for requester 0.
- rsp0_ready  input  1  requester 0 consumes response.
- rsp1_valid  output  1  response pending for requester 1.
- rsp1_ready  input  1  requester 1 consumes response.
- rsp_result  output  32  shared response data, meaningful while rsp0_valid or rsp1_valid is high.
- rsp_cout  output  1  shared response carry.
- alu_opcode  output  3  to ALU.
- alu_a  output  32  to ALU.
- alu_b  output  32  to ALU.
- alu_cin  output  1  to ALU.
- alu_result  input  32  from ALU.
- alu_cout  input  1  from ALU.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset state:
  - FSM goes to IDLE.
  - Command registers (alu_opcode/a/b/cin), rsp_result and rsp_cout are 0.
  - last_grant = GRANT_INIT.
  - All valid/ready outputs and busy are 0.
- Reset mid-operation: any captured command or pending response is dropped with no partial output. The first request is accepted in the cycle after reset deasserts.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection, combinational:
    - Only one valid: that requester wins.
    - Both valid, RR=1: the requester that is not last_grant wins.
    - Both valid, RR=0: requester 0 wins.
  - reqN_ready = 1 only for the winner, and only in IDLE. Requester readiness never depends on rsp_ready.
  - At the clock edge with the handshake, capture opcode/a/b/cin into the command registers and store owner = winner. Go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (exactly one cycle):
  - The ALU is driven from the command registers, so the ALU sees registered inputs for the whole cycle.
  - At the edge, rsp_result <= alu_result and rsp_cout <= alu_cout. Go to RESP.
- RESP:
  - rsp{owner}_valid = 1; the other rsp valid = 0.
  - rsp_result and rsp_cout hold stable until the response is consumed.
  - When rsp{owner}_ready = 1, at the edge: go to IDLE and set last_grant <= owner.
  - rsp_ready from the non-owner is ignored.
- Timing:
  - Latency from request accept to rsp_valid is 2 cycles.
  - Minimum issue interval is 3 cycles when the response is consumed immediately.
  - Backpressure on the response channel stalls the block indefinitely in RESP.
- Requester obligation: after raising reqN_valid, hold valid and payload stable until ready. The block does not check this.
- Carry: rsp_cout is nonzero only for opcode 111, because the ALU forces cout = 0 otherwise. The controller passes alu_cout through unmodified.
- Operands pass through unmodified, including b[5:0] used by the ALU for shift and cut amounts.
- alu_* outputs keep the last command between operations. This is harmless; no idle zeroing is required.

Test Plan:
- Reset, then req0 ADD with a=0xFFFFFFFF, b=0x00000001, cin=0 -> req0_ready pulses in cycle 0; rsp0_valid=1 in cycle 2 with rsp_result=0x00000000 and rsp_cout=1; rsp1_valid stays 0.
- RR=1, GRANT_INIT=0, req0 and req1 both valid continuously, each XOR a=0xF0F0F0F0, b=0xFFFF0000 -> grants go 1,0,1,0; each response is 0x0F0FF0F0 on the matching rsp port; issue interval 3 cycles.
- RR=0, both requesters valid -> req0 always wins and req1_ready stays 0 while req0_valid is held.
- req1 SHL a=0x00000001, b=0x00000004, with rsp1_ready held 0 for 5 cycles -> rsp1_valid stays high with rsp_result=0x00000010 held stable; busy=1; req0_ready=0 throughout; accept resumes the cycle after rsp1_ready=1.
- Assert rst while in EXEC with a CUT command pending -> all outputs 0 immediately (asynchronous); no rsp_valid after release; a new req0 NOT a=0 returns 0xFFFFFFFF in 2 cycles.
- AND command with cin=1 -> rsp_cout=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Arbitrates two requesters onto one shared combinational ALU.
//                The granted command is registered, executed for one cycle,
//                and the result is returned on a valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int RR         = 1,
    parameter int GRANT_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_cin,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_cin,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_cout,

    output logic [2:0]  alu_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,

    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_last_grant;
    logic        r_owner;
    logic [2:0]  r_opcode;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_cin;
    logic [31:0] r_rsp_result;
    logic        r_rsp_cout;

    logic        w_winner;
    logic        w_accept;
    logic        w_rsp_done;

    // Winner is index 1 or 0; round-robin favours whoever was not served last.
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid && req1_valid) begin
            w_winner = (RR != 0) ? ~r_last_grant : 1'b0;
        end else if (req1_valid) begin
            w_winner = 1'b1;
        end
    end

    assign w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign w_rsp_done = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);

    assign req0_ready = w_accept && !w_winner;
    assign req1_ready = w_accept &&  w_winner;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_next = S_EXEC;
            S_EXEC:                  w_state_next = S_RESP;
            S_RESP:  if (w_rsp_done) w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= (GRANT_INIT != 0);
            r_owner      <= 1'b0;
            r_opcode     <= 3'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_cin        <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_cout   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_owner  <= w_winner;
                r_opcode <= w_winner ? req1_opcode : req0_opcode;
                r_a      <= w_winner ? req1_a      : req0_a;
                r_b      <= w_winner ? req1_b      : req0_b;
                r_cin    <= w_winner ? req1_cin    : req0_cin;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_cout   <= alu_cout;
            end
            if (w_rsp_done) begin
                r_last_grant <= r_owner;
            end
        end
    end

    // The ALU sees the held command; it is left untouched while idle.
    assign alu_opcode = r_opcode;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_cin    = r_cin;

    assign rsp0_valid = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid = (r_state == S_RESP) &&  r_owner;
    assign rsp_result = r_rsp_result;
    assign rsp_cout   = r_rsp_cout;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
